vc_output_allocator: RTL and testbench



---
 rtl/vc_output_allocator.sv | 158 +++++++++++++++
 tb/tb_vc_output_allocator.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_output_allocator.sv
// vc_output_allocator: per-output round-robin channel allocator for router VCs.
// Each output is FREE or BUSY. A BUSY output stays locked to its owner VC until
// that VC pulses tail_sent_i. The crossbar select and per-VC grant come straight
// from the registered owners.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   req_vld_i      [IN_N]        VC waits with a header flit
//   req_route_i    [IN_N*OUT_N]  one-hot output request, slice i
//   tail_sent_i    [IN_N]        VC forwarded its tail flit (1-cycle pulse)
//   grant_o        [IN_N]        VC owns an output (chan_alloc)
//   out_sel_o      [OUT_N*IN_N]  one-hot owner of output o, slice o
//   out_busy_o     [OUT_N]       output is allocated
// Optional: define ALLOC_WATCHDOG_EN to force-release an output whose owner
// has held it for 2**WDOG_W cycles without sending a tail.
module vc_output_allocator #(
    parameter int IN_N   = 5,
    parameter int OUT_N  = 5,
    parameter int WDOG_W = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [IN_N-1:0]       req_vld_i,
    input  logic [IN_N*OUT_N-1:0] req_route_i,
    input  logic [IN_N-1:0]       tail_sent_i,
    output logic [IN_N-1:0]       grant_o,
    output logic [OUT_N*IN_N-1:0] out_sel_o,
    output logic [OUT_N-1:0]      out_busy_o
);

    localparam int PW = (IN_N > 1) ? $clog2(IN_N) : 1;

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } st_t;

    st_t             r_st     [OUT_N];
    st_t             w_st_nxt [OUT_N];
    logic [IN_N-1:0] r_own    [OUT_N];
    logic [IN_N-1:0] w_own_nxt[OUT_N];
    logic [PW-1:0]   r_ptr    [OUT_N];
    logic [PW-1:0]   w_ptr_nxt[OUT_N];
    logic [IN_N-1:0] w_elig   [OUT_N];
    logic [IN_N-1:0] w_grant;
    logic [OUT_N-1:0] w_tail_own;
    logic [OUT_N-1:0] w_wd_exp;

    // First set bit of elig at or after ptr, searching cyclically; -1 if none.
    // Scanning downward lets the smallest offset overwrite the result last.
    function automatic int rr_pick(
        input logic [IN_N-1:0] elig,
        input logic [PW-1:0]   ptr
    );
        int idx;
        rr_pick = -1;
        for (int k = IN_N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % IN_N;
            if (elig[idx]) rr_pick = idx;
        end
    endfunction

    always_comb begin
        w_grant    = '0;
        out_sel_o  = '0;
        out_busy_o = '0;
        for (int o = 0; o < OUT_N; o++) begin
            w_grant                  = w_grant | r_own[o];
            out_sel_o[o*IN_N +: IN_N] = r_own[o];
            out_busy_o[o]            = (r_st[o] == BUSY);
        end
    end

    assign grant_o = w_grant;

    // A route equal to exactly (1 << o) is one-hot on o; zero or multi-hot
    // routes never match any output.
    always_comb begin
        for (int o = 0; o < OUT_N; o++) begin
            w_tail_own[o] = |(r_own[o] & tail_sent_i);
            for (int i = 0; i < IN_N; i++) begin
                w_elig[o][i] = req_vld_i[i] & ~w_grant[i] &
                    (req_route_i[i*OUT_N +: OUT_N] == (OUT_N'(1) << o));
            end
        end
    end

    always_comb begin
        int win;
        win = -1;
        for (int o = 0; o < OUT_N; o++) begin
            w_st_nxt[o]  = r_st[o];
            w_own_nxt[o] = r_own[o];
            w_ptr_nxt[o] = r_ptr[o];
            unique case (r_st[o])
                FREE: begin
                    win = rr_pick(w_elig[o], r_ptr[o]);
                    if (win >= 0) begin
                        w_st_nxt[o]  = BUSY;
                        w_own_nxt[o] = IN_N'(1) << win;
                        w_ptr_nxt[o] = PW'((win + 1) % IN_N);
                    end
                end
                BUSY: begin
                    if (w_tail_own[o] || w_wd_exp[o]) begin
                        w_st_nxt[o]  = FREE;
                        w_own_nxt[o] = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int o = 0; o < OUT_N; o++) begin
                r_st[o]  <= FREE;
                r_own[o] <= '0;
                r_ptr[o] <= '0;
            end
        end else begin
            for (int o = 0; o < OUT_N; o++) begin
                r_st[o]  <= w_st_nxt[o];
                r_own[o] <= w_own_nxt[o];
                r_ptr[o] <= w_ptr_nxt[o];
            end
        end
    end

`ifdef ALLOC_WATCHDOG_EN
    logic [WDOG_W-1:0] r_wd[OUT_N];

    always_comb begin
        for (int o = 0; o < OUT_N; o++) begin
            w_wd_exp[o] = (r_st[o] == BUSY) && (&r_wd[o]);
        end
    end

    // Held at zero while FREE, so every new ownership starts from zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int o = 0; o < OUT_N; o++) r_wd[o] <= '0;
        end else begin
            for (int o = 0; o < OUT_N; o++) begin
                if (r_st[o] != BUSY || w_tail_own[o]) begin
                    r_wd[o] <= '0;
                end else if (!(&r_wd[o])) begin
                    r_wd[o] <= r_wd[o] + 1'b1;
                end
            end
        end
    end
`else
    // No watchdog built: outputs never time out for any legal WDOG_W.
    assign w_wd_exp = {OUT_N{WDOG_W < 1}};
`endif

endmodule

// File: tb/tb_vc_output_allocator.sv
// tb_vc_output_allocator: directed and random checks of vc_output_allocator
// against a queue-free integer reference model of owners and pointers.
module tb_vc_output_allocator;

    localparam int IN_N  = 5;
    localparam int OUT_N = 5;
    localparam int WDW   = 3;
    localparam int WMAX  = (1 << WDW) - 1;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [4:0]  req_vld = '0;
    logic [24:0] req_route = '0;
    logic [4:0]  tail = '0;
    logic [4:0]  grant_o;
    logic [24:0] out_sel_o;
    logic [4:0]  out_busy_o;

    int vecs = 0;
    int errs = 0;

    // Model: owner index per output (-1 = free), rr pointer, watchdog count.
    int m_own[OUT_N];
    int m_ptr[OUT_N];
    int m_wd [OUT_N];

    vc_output_allocator #(.IN_N(IN_N), .OUT_N(OUT_N), .WDOG_W(WDW)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .req_vld_i  (req_vld),
        .req_route_i(req_route),
        .tail_sent_i(tail),
        .grant_o    (grant_o),
        .out_sel_o  (out_sel_o),
        .out_busy_o (out_busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] exp_grant();
        logic [4:0] g = '0;
        for (int o = 0; o < OUT_N; o++) if (m_own[o] >= 0) g[m_own[o]] = 1'b1;
        return g;
    endfunction

    function automatic logic [24:0] exp_sel();
        logic [24:0] s = '0;
        for (int o = 0; o < OUT_N; o++)
            if (m_own[o] >= 0) s[o*IN_N + m_own[o]] = 1'b1;
        return s;
    endfunction

    function automatic logic [4:0] exp_busy();
        logic [4:0] b = '0;
        for (int o = 0; o < OUT_N; o++) b[o] = (m_own[o] >= 0);
        return b;
    endfunction

    function automatic void model_reset();
        for (int o = 0; o < OUT_N; o++) begin
            m_own[o] = -1;
            m_ptr[o] = 0;
            m_wd[o]  = 0;
        end
    endfunction

    // Advance the model by one clock from the present inputs, then the DUT.
    task automatic step();
        int nown[OUT_N];
        int nptr[OUT_N];
        int nwd [OUT_N];
        logic [4:0] g;
        int i;
        bit wd_fire;
        g = exp_grant();
        for (int o = 0; o < OUT_N; o++) begin
            nown[o] = m_own[o];
            nptr[o] = m_ptr[o];
            nwd[o]  = m_wd[o];
            wd_fire = 1'b0;
`ifdef ALLOC_WATCHDOG_EN
            wd_fire = (m_own[o] >= 0) && (m_wd[o] == WMAX);
`endif
            if (!rst_ni) begin
                nown[o] = -1;
                nptr[o] = 0;
                nwd[o]  = 0;
            end else if (m_own[o] >= 0) begin
                if (tail[m_own[o]] || wd_fire) nown[o] = -1;
                else if (m_wd[o] < WMAX) nwd[o] = m_wd[o] + 1;
            end else begin
                for (int k = 0; k < IN_N; k++) begin
                    i = (m_ptr[o] + k) % IN_N;
                    if (nown[o] < 0 && req_vld[i] && !g[i] &&
                        req_route[i*OUT_N +: OUT_N] == 5'(1 << o)) begin
                        nown[o] = i;
                        nptr[o] = (i + 1) % IN_N;
                        nwd[o]  = 0;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        for (int o = 0; o < OUT_N; o++) begin
            m_own[o] = nown[o];
            m_ptr[o] = nptr[o];
            m_wd[o]  = nwd[o];
        end
    endtask

    task automatic set_req(input int vc, input logic [4:0] r, input logic v);
        req_route[vc*OUT_N +: OUT_N] = r;
        req_vld[vc] = v;
    endtask

    task automatic pulse_tail(input int vc);
        tail[vc] = 1'b1;
        step();
        tail = '0;
    endtask

    task automatic test_reset();
        vecs++;
        if (grant_o !== 5'b0 || out_sel_o !== 25'b0 || out_busy_o !== 5'b0) begin
            $display("FAIL reset: grant %b sel %h busy %b, want all 0",
                     grant_o, out_sel_o, out_busy_o);
            errs++;
        end
    endtask

    task automatic test_single();
        set_req(2, 5'b00100, 1'b1);
        step();
        set_req(2, 5'b00000, 1'b0);
        vecs++;
        if (grant_o !== 5'b00100 || out_busy_o !== 5'b00100 ||
            out_sel_o[2*IN_N +: IN_N] !== 5'b00100) begin
            $display("FAIL single_grant: grant %b busy %b sel2 %b, want 00100 00100 00100",
                     grant_o, out_busy_o, out_sel_o[10 +: 5]);
            errs++;
        end
        pulse_tail(2);
        vecs++;
        if (grant_o !== 5'b0 || out_busy_o !== 5'b0 || out_sel_o !== 25'b0) begin
            $display("FAIL single_release: grant %b busy %b, want 0 0", grant_o, out_busy_o);
            errs++;
        end
    endtask

    task automatic test_contention();
        logic [4:0] want[3];
        int vc[3];
        want[0] = 5'b00001; want[1] = 5'b00010; want[2] = 5'b01000;
        vc[0] = 0; vc[1] = 1; vc[2] = 3;
        set_req(0, 5'b00010, 1'b1);
        set_req(1, 5'b00010, 1'b1);
        set_req(3, 5'b00010, 1'b1);
        step();
        for (int n = 0; n < 3; n++) begin
            vecs++;
            if (grant_o !== want[n] || out_sel_o[1*IN_N +: IN_N] !== want[n]) begin
                $display("FAIL contention_win%0d: grant %b sel1 %b, want %b",
                         n, grant_o, out_sel_o[5 +: 5], want[n]);
                errs++;
            end
            set_req(vc[n], 5'b00000, 1'b0);
            pulse_tail(vc[n]);
            vecs++;
            if (grant_o !== 5'b0 || out_busy_o[1] !== 1'b0) begin
                $display("FAIL contention_free%0d: grant %b busy1 %b, want 0 0",
                         n, grant_o, out_busy_o[1]);
                errs++;
            end
            if (n < 2) step();
        end
    endtask

    task automatic test_wrap();
        set_req(3, 5'b10000, 1'b1);
        step();
        set_req(3, 5'b00000, 1'b0);
        pulse_tail(3);
        set_req(4, 5'b10000, 1'b1);
        step();
        vecs++;
        if (grant_o !== 5'b10000) begin
            $display("FAIL wrap_vc4: grant %b, want 10000", grant_o);
            errs++;
        end
        pulse_tail(4);
        set_req(0, 5'b10000, 1'b1);
        step();
        vecs++;
        if (grant_o !== 5'b00001 || out_sel_o[4*IN_N +: IN_N] !== 5'b00001) begin
            $display("FAIL wrap_vc0: grant %b sel4 %b, want 00001", grant_o, out_sel_o[20 +: 5]);
            errs++;
        end
        set_req(0, 5'b00000, 1'b0);
        set_req(4, 5'b00000, 1'b0);
        pulse_tail(0);
    endtask

    task automatic test_independence();
        set_req(0, 5'b00001, 1'b1);
        set_req(1, 5'b01000, 1'b1);
        set_req(2, 5'b00110, 1'b1);
        set_req(3, 5'b00000, 1'b1);
        for (int c = 0; c < 4; c++) begin
            step();
            vecs++;
            if (grant_o !== 5'b00011 || out_busy_o !== 5'b01001) begin
                $display("FAIL indep_c%0d: grant %b busy %b, want 00011 01001",
                         c, grant_o, out_busy_o);
                errs++;
            end
        end
        tail = 5'b10100;
        step();
        tail = '0;
        vecs++;
        if (grant_o !== 5'b00011 || out_sel_o !== exp_sel()) begin
            $display("FAIL nonowner_tail: grant %b, want 00011", grant_o);
            errs++;
        end
        req_vld = '0;
        req_route = '0;
        tail = 5'b00011;
        step();
        tail = '0;
    endtask

    task automatic test_reset_mid();
        set_req(0, 5'b00001, 1'b1);
        set_req(1, 5'b00100, 1'b1);
        step();
        set_req(0, 5'b00000, 1'b0);
        set_req(1, 5'b00000, 1'b0);
        vecs++;
        if (out_busy_o !== 5'b00101) begin
            $display("FAIL pre_reset_busy: busy %b, want 00101", out_busy_o);
            errs++;
        end
        set_req(0, 5'b00100, 1'b1);
        set_req(3, 5'b00100, 1'b1);
        #2 rst_ni = 1'b0;
        #1;
        model_reset();
        vecs++;
        if (grant_o !== 5'b0 || out_sel_o !== 25'b0 || out_busy_o !== 5'b0) begin
            $display("FAIL async_reset: grant %b busy %b, want 0 0", grant_o, out_busy_o);
            errs++;
        end
        step();
        rst_ni = 1'b1;
        step();
        vecs++;
        if (grant_o !== 5'b00001 || out_busy_o !== 5'b00100) begin
            $display("FAIL post_reset_regrant: grant %b busy %b, want 00001 00100",
                     grant_o, out_busy_o);
            errs++;
        end
        set_req(0, 5'b00000, 1'b0);
        set_req(3, 5'b00000, 1'b0);
        pulse_tail(0);
    endtask

    task automatic test_watchdog();
        set_req(2, 5'b01000, 1'b1);
        step();
        set_req(2, 5'b00000, 1'b0);
`ifdef ALLOC_WATCHDOG_EN
        for (int c = 1; c <= 8; c++) begin
            step();
            vecs++;
            if (out_busy_o[3] !== (c < 8)) begin
                $display("FAIL wdog_c%0d: busy3 %b, want %b", c, out_busy_o[3], c < 8);
                errs++;
            end
        end
`else
        repeat (100) step();
        vecs++;
        if (out_busy_o[3] !== 1'b1 || grant_o !== 5'b00100) begin
            $display("FAIL no_wdog_hold: busy3 %b grant %b, want 1 00100",
                     out_busy_o[3], grant_o);
            errs++;
        end
        pulse_tail(2);
`endif
    endtask

    task automatic test_random();
        logic [4:0] g;
        for (int c = 0; c < 500; c++) begin
            g = exp_grant();
            for (int i = 0; i < IN_N; i++) begin
                if ($urandom_range(3) != 0)
                    req_route[i*OUT_N +: OUT_N] = 5'(1 << $urandom_range(4));
                else
                    req_route[i*OUT_N +: OUT_N] = 5'($urandom);
                req_vld[i] = ($urandom_range(2) != 0);
                tail[i] = g[i] ? ($urandom_range(3) == 0) : ($urandom_range(7) == 0);
            end
            step();
            vecs++;
            if (grant_o !== exp_grant() || out_sel_o !== exp_sel() ||
                out_busy_o !== exp_busy()) begin
                $display("FAIL random_c%0d: grant %b sel %h busy %b, want %b %h %b",
                         c, grant_o, out_sel_o, out_busy_o,
                         exp_grant(), exp_sel(), exp_busy());
                errs++;
            end
        end
        req_vld = '0;
        tail = '0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_ni = 1'b1;
        test_single();
        test_contention();
        test_wrap();
        test_independence();
        test_reset_mid();
        test_watchdog();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
